sw_out_stage: RTL and testbench

// - Consumer side of the switch allocator: takes the 4 rank-ordered flits plus their allocated

---
 rtl/sw_out_stage_pkg.sv | 22 ++
 rtl/sw_out_stage_if.sv | 30 +++
 rtl/sw_out_stage_out_port_sel.sv | 26 ++
 rtl/sw_out_stage.sv | 126 ++++++++++++
 tb/tb_sw_out_stage.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sw_out_stage_pkg.sv
// Shared constants, error codes and helpers for the switch output stage.
package sw_out_stage_pkg;

  localparam int NUM_PORT = 4;

  // Allocation error codes, also reused by the router-level checker.
  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_COLLISION = 2'b01,
    ERR_UNICAST   = 2'b10,
    ERR_MC_ZERO   = 2'b11
  } errCode_e;

  // Number of set bits in a 4-bit port/channel vector (0..4).
  function automatic logic [2:0] popCount4(input logic [NUM_PORT-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_PORT; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/sw_out_stage_if.sv
// Flit bus between the switch allocator and the output stage.
interface sw_out_stage_if
  import sw_out_stage_pkg::*;
#(
  parameter int FLIT_W = 64
);
  logic [NUM_PORT-1:0] valid_in;
  logic [NUM_PORT-1:0] mc_in;
  logic [FLIT_W-1:0]   flit_0, flit_1, flit_2, flit_3;
  logic [NUM_PORT-1:0] ppv_0, ppv_1, ppv_2, ppv_3;
  logic [NUM_PORT-1:0] allocPV_0, allocPV_1, allocPV_2, allocPV_3;
  logic [NUM_PORT-1:0] out_valid;
  logic [FLIT_W-1:0]   out_flit_0, out_flit_1, out_flit_2, out_flit_3;

  // Allocator / link side.
  modport master (
    output valid_in, mc_in, flit_0, flit_1, flit_2, flit_3,
           ppv_0, ppv_1, ppv_2, ppv_3,
           allocPV_0, allocPV_1, allocPV_2, allocPV_3,
    input  out_valid, out_flit_0, out_flit_1, out_flit_2, out_flit_3
  );

  // Output stage side.
  modport slave (
    input  valid_in, mc_in, flit_0, flit_1, flit_2, flit_3,
           ppv_0, ppv_1, ppv_2, ppv_3,
           allocPV_0, allocPV_1, allocPV_2, allocPV_3,
    output out_valid, out_flit_0, out_flit_1, out_flit_2, out_flit_3
  );
endinterface

// File: rtl/sw_out_stage_out_port_sel.sv
// Per-output-port selector: picks the highest-priority (lowest rank)
// requesting flit and flags when more than one channel claims the port.
module out_port_sel
  import sw_out_stage_pkg::*;
#(
  parameter int FLIT_W = 64
) (
  input  logic [NUM_PORT-1:0] req,
  input  logic [FLIT_W-1:0]   flitIn [NUM_PORT],
  output logic [FLIT_W-1:0]   selFlit,
  output logic                selValid,
  output logic                collision
);

  // Priority mux (lowest rank wins) plus valid and collision flags.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    selFlit   = '0;
    selValid  = |req;
    collision = (popCount4(req) >= 3'd2);
    for (int c = NUM_PORT - 1; c >= 0; c--) begin
      if (req[c]) selFlit = flitIn[c];
    end
  end

endmodule

// File: rtl/sw_out_stage.sv
// Switch output stage: steers ranked flits onto their granted output links,
// registers them, checks allocator results and keeps deflection statistics.
module sw_out_stage
  import sw_out_stage_pkg::*;
#(
  parameter int FLIT_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_stats,
  sw_out_stage_if.slave      bus,
  output logic [CNT_W-1:0]   defl_cnt,
  output logic [CNT_W-1:0]   flit_cnt,
  output logic               err_sticky,
  output logic [1:0]         err_code
);

  logic [FLIT_W-1:0]   flitArr  [NUM_PORT];
  logic [NUM_PORT-1:0] allocArr [NUM_PORT];
  logic [NUM_PORT-1:0] ppvArr   [NUM_PORT];
  logic [NUM_PORT-1:0] reqVec   [NUM_PORT];
  logic [FLIT_W-1:0]   selFlit  [NUM_PORT];
  logic [NUM_PORT-1:0] selValid;
  logic [NUM_PORT-1:0] collVec;
  logic [FLIT_W-1:0]   outFlitQ [NUM_PORT];
  logic [NUM_PORT-1:0] outValidQ;
  logic [2:0]          deflInc;
  logic                uniErr, mcErr, anyErr;
  errCode_e            errNext, errCodeQ;

  assign flitArr  = '{bus.flit_0, bus.flit_1, bus.flit_2, bus.flit_3};
  assign allocArr = '{bus.allocPV_0, bus.allocPV_1, bus.allocPV_2, bus.allocPV_3};
  assign ppvArr   = '{bus.ppv_0, bus.ppv_1, bus.ppv_2, bus.ppv_3};

  // Clamp an increment of 0..4 so the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W - 2){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Transpose grants into per-output request vectors; invalid channels drop out.
  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      reqVec[p] = '0;
      for (int c = 0; c < NUM_PORT; c++) reqVec[p][c] = bus.valid_in[c] & allocArr[c][p];
    end
  end

  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    out_port_sel #(.FLIT_W(FLIT_W)) u_sel (
      .req       (reqVec[p]),
      .flitIn    (flitArr),
      .selFlit   (selFlit[p]),
      .selValid  (selValid[p]),
      .collision (collVec[p])
    );
  end

  // Per-channel grant checks, deflection count and prioritised error code.
  always_comb begin
    uniErr  = 1'b0;
    mcErr   = 1'b0;
    deflInc = '0;
    for (int c = 0; c < NUM_PORT; c++) begin
      if (bus.valid_in[c]) begin
        if (bus.mc_in[c]) begin
          if (allocArr[c] == '0) mcErr = 1'b1;
        end else if (popCount4(allocArr[c]) != 3'd1) begin
          uniErr = 1'b1;
        end
        if ((allocArr[c] != '0) && ((allocArr[c] & ppvArr[c]) == '0)) deflInc = deflInc + 3'd1;
      end
    end
    anyErr = (|collVec) | uniErr | mcErr;
    if (|collVec)   errNext = ERR_COLLISION;
    else if (uniErr) errNext = ERR_UNICAST;
    else if (mcErr)  errNext = ERR_MC_ZERO;
    else             errNext = ERR_NONE;
  end

  // Output link registers; an idle port keeps its last flit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      outValidQ <= '0;
      for (int p = 0; p < NUM_PORT; p++) outFlitQ[p] <= '0;
    end else begin
      outValidQ <= selValid;
      for (int p = 0; p < NUM_PORT; p++) begin
        if (selValid[p]) outFlitQ[p] <= selFlit[p];
      end
    end
  end

  // Statistics and first-error capture; clear beats same-cycle events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      defl_cnt   <= '0;
      flit_cnt   <= '0;
      err_sticky <= 1'b0;
      errCodeQ   <= ERR_NONE;
    end else if (clr_stats) begin
      defl_cnt   <= '0;
      flit_cnt   <= '0;
      err_sticky <= 1'b0;
      errCodeQ   <= ERR_NONE;
    end else begin
      defl_cnt <= satAdd(defl_cnt, deflInc);
      flit_cnt <= satAdd(flit_cnt, popCount4(bus.valid_in));
      if (anyErr && !err_sticky) begin
        err_sticky <= 1'b1;
        errCodeQ   <= errNext;
      end
    end
  end

  assign err_code       = errCodeQ;
  assign bus.out_valid  = outValidQ;
  assign bus.out_flit_0 = outFlitQ[0];
  assign bus.out_flit_1 = outFlitQ[1];
  assign bus.out_flit_2 = outFlitQ[2];
  assign bus.out_flit_3 = outFlitQ[3];

endmodule

// File: tb/tb_sw_out_stage.sv
// Directed self-checking bench for sw_out_stage (small counters to reach saturation quickly).
module tb_sw_out_stage;
  import sw_out_stage_pkg::*;

  localparam int FLIT_W = 64;
  localparam int CNT_W  = 4;
  localparam logic [FLIT_W-1:0] F0 = 64'hF000_0000_0000_00A0;
  localparam logic [FLIT_W-1:0] F1 = 64'h0F00_0000_0000_00B1;
  localparam logic [FLIT_W-1:0] F2 = 64'h00F0_0000_0000_00C2;
  localparam logic [FLIT_W-1:0] F3 = 64'h000F_0000_0000_00D3;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr_stats;
  logic [CNT_W-1:0] defl_cnt, flit_cnt;
  logic             err_sticky;
  logic [1:0]       err_code;
  int               passed = 0;
  int               total  = 0;

  sw_out_stage_if #(.FLIT_W(FLIT_W)) bus ();

  sw_out_stage #(.FLIT_W(FLIT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr_stats  (clr_stats),
    .bus        (bus),
    .defl_cnt   (defl_cnt),
    .flit_cnt   (flit_cnt),
    .err_sticky (err_sticky),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one cycle of stimulus at the falling edge, then sample just after the rising edge.
  task automatic apply(input logic clr, input logic [3:0] v, input logic [3:0] mc,
                       input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                       input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] p3);
    @(negedge clk);
    clr_stats = clr;
    bus.valid_in = v;   bus.mc_in = mc;
    bus.allocPV_0 = a0; bus.allocPV_1 = a1; bus.allocPV_2 = a2; bus.allocPV_3 = a3;
    bus.ppv_0 = p0;     bus.ppv_1 = p1;     bus.ppv_2 = p2;     bus.ppv_3 = p3;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 4'b0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic perm();
    apply(1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000);
  endtask

  task automatic test_reset();
    reset = 1'b1; clr_stats = 1'b0;
    bus.valid_in = '0; bus.mc_in = '0;
    bus.flit_0 = F0; bus.flit_1 = F1; bus.flit_2 = F2; bus.flit_3 = F3;
    bus.allocPV_0 = '0; bus.allocPV_1 = '0; bus.allocPV_2 = '0; bus.allocPV_3 = '0;
    bus.ppv_0 = '0; bus.ppv_1 = '0; bus.ppv_2 = '0; bus.ppv_3 = '0;
    #12;
    total++; if (bus.out_flit_0 !== '0) $display("FAIL reset out_flit_0 got=%h exp=0", bus.out_flit_0); else passed++;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 10; i++) idle();
    total++; if (bus.out_valid !== 4'b0000) $display("FAIL idle out_valid got=%b exp=0000", bus.out_valid); else passed++;
    total++; if (flit_cnt !== 4'd0) $display("FAIL idle flit_cnt got=%0d exp=0", flit_cnt); else passed++;
    total++; if (defl_cnt !== 4'd0) $display("FAIL idle defl_cnt got=%0d exp=0", defl_cnt); else passed++;
    total++; if (err_sticky !== 1'b0) $display("FAIL idle err_sticky got=%b exp=0", err_sticky); else passed++;
    total++; if (err_code !== 2'b00) $display("FAIL idle err_code got=%b exp=00", err_code); else passed++;
  endtask

  task automatic test_permutation();
    perm();
    total++; if (bus.out_valid !== 4'b1111) $display("FAIL perm out_valid got=%b exp=1111", bus.out_valid); else passed++;
    total++; if (bus.out_flit_0 !== F0) $display("FAIL perm out_flit_0 got=%h exp=%h", bus.out_flit_0, F0); else passed++;
    total++; if (bus.out_flit_1 !== F1) $display("FAIL perm out_flit_1 got=%h exp=%h", bus.out_flit_1, F1); else passed++;
    total++; if (bus.out_flit_2 !== F2) $display("FAIL perm out_flit_2 got=%h exp=%h", bus.out_flit_2, F2); else passed++;
    total++; if (bus.out_flit_3 !== F3) $display("FAIL perm out_flit_3 got=%h exp=%h", bus.out_flit_3, F3); else passed++;
    total++; if (flit_cnt !== 4'd4) $display("FAIL perm flit_cnt got=%0d exp=4", flit_cnt); else passed++;
    total++; if (defl_cnt !== 4'd0) $display("FAIL perm defl_cnt got=%0d exp=0", defl_cnt); else passed++;
    idle();
    total++; if (bus.out_valid !== 4'b0000) $display("FAIL hold out_valid got=%b exp=0000", bus.out_valid); else passed++;
    total++; if (bus.out_flit_3 !== F3) $display("FAIL hold out_flit_3 got=%h exp=%h", bus.out_flit_3, F3); else passed++;
  endtask

  task automatic test_deflection();
    apply(1'b0, 4'b0010, 4'b0000, 4'h0, 4'b0100, 4'h0, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0);
    total++; if (bus.out_valid !== 4'b0100) $display("FAIL defl out_valid got=%b exp=0100", bus.out_valid); else passed++;
    total++; if (bus.out_flit_2 !== F1) $display("FAIL defl out_flit_2 got=%h exp=%h", bus.out_flit_2, F1); else passed++;
    total++; if (defl_cnt !== 4'd1) $display("FAIL defl defl_cnt got=%0d exp=1", defl_cnt); else passed++;
    total++; if (flit_cnt !== 4'd5) $display("FAIL defl flit_cnt got=%0d exp=5", flit_cnt); else passed++;
    total++; if (err_sticky !== 1'b0) $display("FAIL defl err_sticky got=%b exp=0", err_sticky); else passed++;
  endtask

  task automatic test_multicast();
    apply(1'b0, 4'b0001, 4'b0001, 4'b0110, 4'h0, 4'h0, 4'h0, 4'b0110, 4'h0, 4'h0, 4'h0);
    total++; if (bus.out_valid !== 4'b0110) $display("FAIL mc out_valid got=%b exp=0110", bus.out_valid); else passed++;
    total++; if (bus.out_flit_1 !== F0) $display("FAIL mc out_flit_1 got=%h exp=%h", bus.out_flit_1, F0); else passed++;
    total++; if (bus.out_flit_2 !== F0) $display("FAIL mc out_flit_2 got=%h exp=%h", bus.out_flit_2, F0); else passed++;
    total++; if (err_sticky !== 1'b0) $display("FAIL mc err_sticky got=%b exp=0", err_sticky); else passed++;
    total++; if (flit_cnt !== 4'd6) $display("FAIL mc flit_cnt got=%0d exp=6", flit_cnt); else passed++;
  endtask

  task automatic test_collision();
    apply(1'b0, 4'b0101, 4'b0000, 4'b0001, 4'h0, 4'b0001, 4'h0, 4'b0001, 4'h0, 4'b0001, 4'h0);
    total++; if (bus.out_valid !== 4'b0001) $display("FAIL coll out_valid got=%b exp=0001", bus.out_valid); else passed++;
    total++; if (bus.out_flit_0 !== F0) $display("FAIL coll out_flit_0 got=%h exp=%h", bus.out_flit_0, F0); else passed++;
    total++; if (err_code !== 2'b01) $display("FAIL coll err_code got=%b exp=01", err_code); else passed++;
    total++; if (err_sticky !== 1'b1) $display("FAIL coll err_sticky got=%b exp=1", err_sticky); else passed++;
    // Unicast with no grant: a second, different error must not overwrite the first.
    apply(1'b0, 4'b0001, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, 4'h0);
    total++; if (err_code !== 2'b01) $display("FAIL keep err_code got=%b exp=01", err_code); else passed++;
    total++; if (bus.out_valid !== 4'b0000) $display("FAIL drop out_valid got=%b exp=0000", bus.out_valid); else passed++;
    total++; if (flit_cnt !== 4'd9) $display("FAIL drop flit_cnt got=%0d exp=9", flit_cnt); else passed++;
    total++; if (defl_cnt !== 4'd1) $display("FAIL drop defl_cnt got=%0d exp=1", defl_cnt); else passed++;
  endtask

  task automatic test_errors();
    apply(1'b1, 4'b0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    total++; if (err_sticky !== 1'b0) $display("FAIL clr err_sticky got=%b exp=0", err_sticky); else passed++;
    total++; if (err_code !== 2'b00) $display("FAIL clr err_code got=%b exp=00", err_code); else passed++;
    total++; if (flit_cnt !== 4'd0) $display("FAIL clr flit_cnt got=%0d exp=0", flit_cnt); else passed++;
    // Multicast with zero grants.
    apply(1'b0, 4'b0001, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, 4'h0);
    total++; if (err_code !== 2'b11) $display("FAIL mczero err_code got=%b exp=11", err_code); else passed++;
    total++; if (err_sticky !== 1'b1) $display("FAIL mczero err_sticky got=%b exp=1", err_sticky); else passed++;
    // Unicast with two grants is replicated; ch1 deflected onto port 2.
    apply(1'b1, 4'b0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    apply(1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0100, 4'h0, 4'h0, 4'b0001, 4'b1000, 4'h0, 4'h0);
    total++; if (err_code !== 2'b10) $display("FAIL uni2 err_code got=%b exp=10", err_code); else passed++;
    total++; if (bus.out_valid !== 4'b0111) $display("FAIL uni2 out_valid got=%b exp=0111", bus.out_valid); else passed++;
    total++; if (bus.out_flit_1 !== F0) $display("FAIL uni2 out_flit_1 got=%h exp=%h", bus.out_flit_1, F0); else passed++;
    total++; if (bus.out_flit_2 !== F1) $display("FAIL uni2 out_flit_2 got=%h exp=%h", bus.out_flit_2, F1); else passed++;
    total++; if (defl_cnt !== 4'd1) $display("FAIL uni2 defl_cnt got=%0d exp=1", defl_cnt); else passed++;
    // Same-cycle collision and multicast-zero: collision code wins.
    apply(1'b1, 4'b0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    apply(1'b0, 4'b0111, 4'b0100, 4'b0001, 4'b0001, 4'h0, 4'h0, 4'b0001, 4'b0001, 4'b0001, 4'h0);
    total++; if (err_code !== 2'b01) $display("FAIL prio err_code got=%b exp=01", err_code); else passed++;
    total++; if (bus.out_flit_0 !== F0) $display("FAIL prio out_flit_0 got=%h exp=%h", bus.out_flit_0, F0); else passed++;
  endtask

  task automatic test_saturation();
    apply(1'b1, 4'b0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    perm(); perm(); perm();
    apply(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'h0, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, 4'h0);
    total++; if (flit_cnt !== 4'd13) $display("FAIL sat pre flit_cnt got=%0d exp=13", flit_cnt); else passed++;
    perm();
    total++; if (flit_cnt !== 4'd15) $display("FAIL sat clamp flit_cnt got=%0d exp=15", flit_cnt); else passed++;
    perm();
    total++; if (flit_cnt !== 4'd15) $display("FAIL sat hold flit_cnt got=%0d exp=15", flit_cnt); else passed++;
    apply(1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000);
    total++; if (flit_cnt !== 4'd0) $display("FAIL clrwin flit_cnt got=%0d exp=0", flit_cnt); else passed++;
    total++; if (bus.out_valid !== 4'b1111) $display("FAIL clrwin out_valid got=%b exp=1111", bus.out_valid); else passed++;
  endtask

  task automatic test_async_reset();
    perm();
    #2 reset = 1'b1;
    #1;
    total++; if (bus.out_valid !== 4'b0000) $display("FAIL areset out_valid got=%b exp=0000", bus.out_valid); else passed++;
    total++; if (bus.out_flit_3 !== '0) $display("FAIL areset out_flit_3 got=%h exp=0", bus.out_flit_3); else passed++;
    total++; if (flit_cnt !== 4'd0) $display("FAIL areset flit_cnt got=%0d exp=0", flit_cnt); else passed++;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 4'b1111) $display("FAIL release out_valid got=%b exp=1111", bus.out_valid); else passed++;
    total++; if (flit_cnt !== 4'd4) $display("FAIL release flit_cnt got=%0d exp=4", flit_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_permutation();
    test_deflection();
    test_multicast();
    test_collision();
    test_errors();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
